// File: rtl/systolic_array_feeder_pkg.sv
// Shared constants, FSM encoding and element indexing for the 3x3 systolic feeder.
package systolic_array_feeder_pkg;
  localparam int N        = 3;
  localparam int CW       = 4;
  localparam int FEED_LEN = 2 * N;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_e;

  function automatic int idx(input int r, input int c);
    return N * r + c;
  endfunction
endpackage

// File: rtl/systolic_array_feeder_if.sv
// Load port and array-side stream bundle of the systolic feeder.
interface systolic_array_feeder_if #(parameter int DATAWIDTN = 8);
  logic                   in_valid;
  logic                   in_ready;
  logic [9*DATAWIDTN-1:0] a_mat;
  logic [9*DATAWIDTN-1:0] b_mat;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic [DATAWIDTN-1:0]   A0, A1, A2;
  logic [DATAWIDTN-1:0]   B0, B1, B2;

  modport slave (
    input  in_valid, a_mat, b_mat,
    output in_ready, start, busy, done, A0, A1, A2, B0, B1, B2
  );
  modport master (
    output in_valid, a_mat, b_mat,
    input  in_ready, start, busy, done, A0, A1, A2, B0, B1, B2
  );
endinterface

// File: rtl/systolic_array_feeder_skew_lane.sv
// One skewed stream lane: emits vec[cyc-LANE] while that index lies in 0..N-1, else 0.
module skew_lane
  import systolic_array_feeder_pkg::*;
#(
  parameter int DW   = 8,
  parameter int LANE = 0
) (
  input  logic [N-1:0][DW-1:0] vec_i,
  input  logic [CW-1:0]        cyc_i,
  input  logic                 en_i,
  output logic [DW-1:0]        el_o
);
  // Extra MSB catches cyc < LANE as a borrow.
  logic [CW:0] diff;
  assign diff = {1'b0, cyc_i} - (CW+1)'(LANE);

  always_comb begin
    el_o = '0;
    if (en_i && !diff[CW] && (diff[CW-1:0] < CW'(N)))
      el_o = vec_i[diff[1:0]];
  end
endmodule

// File: rtl/systolic_array_feeder.sv
// Captures an operand pair, then streams it diagonally skewed into a 3x3 systolic array.
module systolic_array_feeder
  import systolic_array_feeder_pkg::*;
#(
  parameter int DATAWIDTN = 8,
  parameter int RUN_LEN   = 8
) (
  input logic                     CLK,
  input logic                     RST,
  systolic_array_feeder_if.slave  bus
);
  localparam int DW = DATAWIDTN;

  state_e                     state_q, state_d;
  logic [CW-1:0]              cyc_q, cyc_d;
  logic [N*N-1:0][DW-1:0]     a_q, a_d, b_q, b_d;
  logic [N-1:0][N-1:0][DW-1:0] row_v, col_v;
  logic [N-1:0][DW-1:0]       a_lane, b_lane, a_str_q, b_str_q;
  logic                       start_q, done_q, rdy_q;
  logic                       feed_d;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = FEED;
        cyc_d   = '0;
        a_d     = bus.a_mat;
        b_d     = bus.b_mat;
      end
      default: if (cyc_q == CW'(RUN_LEN-1)) begin
        state_d = IDLE;
        cyc_d   = '0;
      end else begin
        cyc_d   = cyc_q + 1'b1;
        state_d = (cyc_d >= CW'(FEED_LEN)) ? DRAIN : FEED;
      end
    endcase
  end

  assign feed_d = (state_d == FEED);

  // Lanes look at next-state values so the stream registers hold cycle c's data during cycle c.
  for (genvar i = 0; i < N; i++) begin : g_lane
    for (genvar k = 0; k < N; k++) begin : g_el
      assign row_v[i][k] = a_d[idx(i, k)];
      assign col_v[i][k] = b_d[idx(k, i)];
    end
    skew_lane #(.DW(DW), .LANE(i)) u_row (
      .vec_i(row_v[i]), .cyc_i(cyc_d), .en_i(feed_d), .el_o(a_lane[i])
    );
    skew_lane #(.DW(DW), .LANE(i)) u_col (
      .vec_i(col_v[i]), .cyc_i(cyc_d), .en_i(feed_d), .el_o(b_lane[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      a_str_q <= '0;
      b_str_q <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_str_q <= a_lane;
      b_str_q <= b_lane;
      start_q <= (state_d != IDLE);
      done_q  <= (state_d != IDLE) && (cyc_d == CW'(RUN_LEN-1));
      rdy_q   <= (state_d == IDLE);
    end
  end

  assign bus.A0       = a_str_q[0];
  assign bus.A1       = a_str_q[1];
  assign bus.A2       = a_str_q[2];
  assign bus.B0       = b_str_q[0];
  assign bus.B1       = b_str_q[1];
  assign bus.B2       = b_str_q[2];
  assign bus.start    = start_q;
  assign bus.busy     = start_q;
  assign bus.done     = done_q;
  assign bus.in_ready = rdy_q;
endmodule

// File: tb/tb_systolic_array_feeder.sv
// Bench: matrix-level reference of the skewed streams plus a behavioural 3x3 array consuming them.
module tb_systolic_array_feeder;
  localparam int DW = 8;
  localparam int RL = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_array_feeder_if #(.DATAWIDTN(DW)) bus();
  systolic_array_feeder #(.DATAWIDTN(DW), .RUN_LEN(RL)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int Am[3][3], Bm[3][3];   // matrices captured by the model at accept
  int nA[3][3], nB[3][3];   // matrices currently driven
  int run_c = -1;           // model cycle index within a run, -1 when idle
  bit armed = 1'b0;
  int acc[3][3], ar[3][3], br[3][3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit v);
    bus.in_valid = v;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        bus.a_mat[(3*r+c)*DW +: DW] = DW'(nA[r][c]);
        bus.b_mat[(3*r+c)*DW +: DW] = DW'(nB[r][c]);
      end
  endtask

  task automatic rand_mats();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        nA[r][c] = $urandom_range(0, 255);
        nB[r][c] = $urandom_range(0, 255);
      end
  endtask

  task automatic basic_mats();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        nA[r][c] = 3*r + c + 1;
        nB[r][c] = 3*r + c + 10;
      end
  endtask

  // Reference: run position advances one per cycle after an accepted pair, RUN_LEN cycles long.
  always @(posedge clk) begin
    if (rst) begin
      run_c = -1;
      armed = 1'b1;
    end else if (run_c < 0) begin
      if (bus.in_valid) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) begin
            Am[r][c] = int'(bus.a_mat[(3*r+c)*DW +: DW]);
            Bm[r][c] = int'(bus.b_mat[(3*r+c)*DW +: DW]);
          end
        run_c = 0;
      end
    end else begin
      run_c++;
      if (run_c == RL) run_c = -1;
    end
  end

  function automatic int exp_a(input int i);
    int k = run_c - i;
    if (run_c >= 0 && k >= 0 && k <= 2) return Am[i][k];
    return 0;
  endfunction

  function automatic int exp_b(input int i);
    int k = run_c - i;
    if (run_c >= 0 && k >= 0 && k <= 2) return Bm[k][i];
    return 0;
  endfunction

  always @(negedge clk) begin
    logic [63:0] ev, av;
    int sa[3], sb[3], ai[3][3], bi[3][3], p;
    if (armed) begin
      ev = '0;
      ev[51:0] = {DW'(exp_a(0)), DW'(exp_a(1)), DW'(exp_a(2)),
                  DW'(exp_b(0)), DW'(exp_b(1)), DW'(exp_b(2)),
                  run_c >= 0, run_c >= 0, run_c == RL-1, run_c < 0};
      av = '0;
      av[51:0] = {bus.A0, bus.A1, bus.A2, bus.B0, bus.B1, bus.B2,
                  bus.start, bus.busy, bus.done, bus.in_ready};
      chk($sformatf("model c%0d {A,B,start,busy,done,rdy}", run_c), av, ev);

      // Behavioural systolic array fed by the DUT streams.
      if (run_c == 0)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            acc[i][j] = 0; ar[i][j] = 0; br[i][j] = 0;
          end
      if (run_c >= 0) begin
        sa[0] = int'(bus.A0); sa[1] = int'(bus.A1); sa[2] = int'(bus.A2);
        sb[0] = int'(bus.B0); sb[1] = int'(bus.B1); sb[2] = int'(bus.B2);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            ai[i][j] = (j == 0) ? sa[i] : ar[i][j-1];
            bi[i][j] = (i == 0) ? sb[j] : br[i-1][j];
          end
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            acc[i][j] += ai[i][j] * bi[i][j];
            ar[i][j] = ai[i][j];
            br[i][j] = bi[i][j];
          end
      end
      if (run_c == RL-1)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            p = 0;
            for (int k = 0; k < 3; k++) p += Am[i][k] * Bm[k][j];
            chk($sformatf("array C[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(p));
          end
    end
  end

  task automatic run_basic(input string tag);
    basic_mats();
    put(1'b1);
    tick();
    put(1'b0);
    for (int c = 0; c <= 8; c++) begin
      case (c)
        0: begin chk({tag, " c0 A0"}, bus.A0, 1);  chk({tag, " c0 B0"}, bus.B0, 10);
                 chk({tag, " c0 A1"}, bus.A1, 0);  chk({tag, " c0 start"}, bus.start, 1); end
        1: begin chk({tag, " c1 A0"}, bus.A0, 2);  chk({tag, " c1 A1"}, bus.A1, 4);
                 chk({tag, " c1 B0"}, bus.B0, 13); chk({tag, " c1 B1"}, bus.B1, 11); end
        2: begin chk({tag, " c2 A2"}, bus.A2, 7);  chk({tag, " c2 B2"}, bus.B2, 12);
                 chk({tag, " c2 A1"}, bus.A1, 5);  chk({tag, " c2 B0"}, bus.B0, 16); end
        3: begin chk({tag, " c3 A1"}, bus.A1, 6);  chk({tag, " c3 B2"}, bus.B2, 15); end
        4: begin chk({tag, " c4 A2"}, bus.A2, 9);  chk({tag, " c4 B2"}, bus.B2, 18); end
        5: begin chk({tag, " c5 A2"}, bus.A2, 0);  chk({tag, " c5 B2"}, bus.B2, 0); end
        6: begin chk({tag, " c6 done"}, bus.done, 0); chk({tag, " c6 start"}, bus.start, 1); end
        7: begin chk({tag, " c7 done"}, bus.done, 1); chk({tag, " c7 start"}, bus.start, 1); end
        8: begin chk({tag, " c8 start"}, bus.start, 0); chk({tag, " c8 in_ready"}, bus.in_ready, 1);
                 chk({tag, " c8 done"}, bus.done, 0); end
        default: ;
      endcase
      if (c < 8) tick();
    end
  endtask

  initial begin
    int c;
    int sav[3][3];
    bus.in_valid = 1'b0;
    bus.a_mat = '0;
    bus.b_mat = '0;

    // Reset held three cycles
    rst = 1'b1;
    repeat (3) tick();
    chk("reset streams", {bus.A0, bus.A1, bus.A2, bus.B0, bus.B1, bus.B2}, 0);
    chk("reset start/busy/done", {bus.start, bus.busy, bus.done}, 0);
    chk("reset in_ready", bus.in_ready, 1);
    rst = 1'b0;
    tick();

    // Skew pattern
    run_basic("skew");
    tick();

    // Identity x identity through the array
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) begin
        nA[r][k] = (r == k); nB[r][k] = (r == k);
      end
    put(1'b1);
    tick();
    put(1'b0);
    repeat (RL) tick();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("identity C[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(i == j));

    // Busy rejection: new pair offered from c2, accepted only at c8
    rand_mats();
    put(1'b1);
    tick();
    put(1'b0);
    tick(); tick();
    rand_mats();
    sav = nA;
    c = 2;
    while (bus.in_ready !== 1'b1 && c < 20) begin
      rand_mats();
      put(1'b1);
      tick();
      c++;
    end
    chk("busy accept cycle", 64'(c), 64'(8));
    nA = sav;
    put(1'b1);
    tick();
    put(1'b0);
    chk("busy new run A0", bus.A0, 64'(sav[0][0]));
    repeat (RL) tick();

    // Reset mid-run at c3, then same-cycle valid+reset
    basic_mats();
    put(1'b1);
    tick();
    put(1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst streams", {bus.A0, bus.A1, bus.A2, bus.B0, bus.B1, bus.B2}, 0);
    chk("midrst start/done", {bus.start, bus.done}, 0);
    chk("midrst in_ready", bus.in_ready, 1);
    put(1'b1);
    tick();
    rst = 1'b0;
    put(1'b0);
    tick();
    chk("rst+valid no capture", bus.start, 0);
    run_basic("rerun");
    tick();

    // Max values
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) begin
        nA[r][k] = 255; nB[r][k] = 255;
      end
    put(1'b1);
    tick();
    put(1'b0);
    chk("max c0 A0", bus.A0, 8'hFF);
    chk("max c0 A1", bus.A1, 0);
    tick(); tick();
    chk("max c2 B1", bus.B1, 8'hFF);
    repeat (3) tick();
    chk("max c5 streams", {bus.A0, bus.A1, bus.A2, bus.B0, bus.B1, bus.B2}, 0);
    repeat (4) tick();

    // Random traffic with occasional resets
    for (int n = 0; n < 300; n++) begin
      rand_mats();
      put($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    put(1'b0);
    repeat (RL + 2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
